// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-RAM arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {GNT_IDLE, GNT_CPU, GNT_PS2, GNT_VGA} grant_t;

  localparam int PS2_WORD       = 62;
  localparam int VGA_WORD       = 63;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/ps2_wr_buffer.sv
// One-entry valid/ready holding register for PS/2 scancodes awaiting a RAM slot.
module ps2_wr_buffer #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid_i,
  input  logic [M-1:0] wr_data_i,
  output logic         wr_ready_o,
  input  logic         drain_i,
  output logic         full_o,
  output logic [M-1:0] data_o
);

  logic         full_q, full_d;
  logic         ready_q;
  logic [M-1:0] data_q;
  logic         accept;

  // ready is a registered copy of !full, so an offer in the drain cycle is refused
  assign accept = wr_valid_i && ready_q;

  always_comb begin
    full_d = full_q;
    if (drain_i)     full_d = 1'b0;
    else if (accept) full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
      if (accept) data_q <= wr_data_i;
    end
  end

  assign wr_ready_o = ready_q;
  assign full_o     = full_q;
  assign data_o     = data_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Serializes CPU, PS/2 writer and VGA reader onto the single data-RAM port.
// CPU has priority, bounded by a starvation counter; PS/2 and VGA alternate.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int M          = 32,
  parameter int AW         = 6,
  parameter int PS2_ADDR   = PS2_WORD,
  parameter int VGA_ADDR   = VGA_WORD,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [M-1:0]  cpu_a,
  input  logic [M-1:0]  cpu_wd,
  output logic [M-1:0]  cpu_rd,
  output logic          cpu_stall,
  input  logic          ps2_valid,
  input  logic [M-1:0]  ps2_data,
  output logic          ps2_ready,
  input  logic          vga_req,
  output logic [M-1:0]  vga_rd,
  output logic          vga_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [M-1:0]  mem_wd,
  input  logic [M-1:0]  mem_rd
);

  localparam int          SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  grant_t          state_q, state_d;
  grant_t          last_side_q, last_side_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            vga_pend_q, vga_pend_d;
  logic            vga_valid_q;
  logic [M-1:0]    vga_rd_q;
  logic            buf_full;
  logic [M-1:0]    buf_data;
  logic            other_pend;
  logic            unused_cpu_a_bits;

  assign unused_cpu_a_bits = ^{cpu_a[M-1:AW+2], cpu_a[1:0]};

  ps2_wr_buffer #(.M(M)) u_ps2_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (ps2_valid),
    .wr_data_i  (ps2_data),
    .wr_ready_o (ps2_ready),
    .drain_i    (state_d == GNT_PS2),
    .full_o     (buf_full),
    .data_o     (buf_data)
  );

  assign other_pend = buf_full || vga_pend_q;

  // last_side_d folds in the previous cycle's grant so round-robin sees it immediately
  always_comb begin
    state_d     = GNT_IDLE;
    last_side_d = (state_q == GNT_PS2 || state_q == GNT_VGA) ? state_q : last_side_q;
    if (rst)                                  state_d = GNT_IDLE;
    else if (cpu_req && starve_q < STARVE_LIM) state_d = GNT_CPU;
    else if (buf_full && vga_pend_q)          state_d = (last_side_d == GNT_VGA) ? GNT_PS2 : GNT_VGA;
    else if (buf_full)                        state_d = GNT_PS2;
    else if (vga_pend_q)                      state_d = GNT_VGA;
    else if (cpu_req)                         state_d = GNT_CPU;
  end

  always_comb begin
    starve_d = starve_q;
    if (state_d == GNT_PS2 || state_d == GNT_VGA || !other_pend) starve_d = '0;
    else if (state_d == GNT_CPU && starve_q < STARVE_LIM)         starve_d = starve_q + SW'(1);
    vga_pend_d = (vga_pend_q && state_d != GNT_VGA) || vga_req;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    case (state_d)
      GNT_CPU: begin
        mem_we   = cpu_we;
        mem_addr = cpu_a[AW+1:2];
        mem_wd   = cpu_wd;
      end
      GNT_PS2: begin
        mem_we   = 1'b1;
        mem_addr = AW'(PS2_ADDR);
        mem_wd   = buf_data;
      end
      GNT_VGA: mem_addr = AW'(VGA_ADDR);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GNT_IDLE;
      last_side_q <= GNT_VGA;
      starve_q    <= '0;
      vga_pend_q  <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_side_q <= last_side_d;
      starve_q    <= starve_d;
      vga_pend_q  <= vga_pend_d;
      vga_valid_q <= (state_d == GNT_VGA);
      if (state_d == GNT_VGA) vga_rd_q <= mem_rd;
    end
  end

  assign cpu_rd    = mem_rd;
  assign cpu_stall = cpu_req && (state_d != GNT_CPU) && !rst;
  assign vga_rd    = vga_rd_q;
  assign vga_valid = vga_valid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word RAM on the mem_* port.
module tb_dmem_arbiter;

  localparam int M  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [M-1:0]  cpu_a, cpu_wd, cpu_rd;
  logic          cpu_stall;
  logic          ps2_valid;
  logic [M-1:0]  ps2_data;
  logic          ps2_ready;
  logic          vga_req;
  logic [M-1:0]  vga_rd;
  logic          vga_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [M-1:0]  mem_wd, mem_rd;

  logic [M-1:0]  ram [0:63] = '{default: '0};
  int            ps2_wr_cnt = 0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.M(M), .AW(AW), .PS2_ADDR(62), .VGA_ADDR(63), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_a     (cpu_a),
    .cpu_wd    (cpu_wd),
    .cpu_rd    (cpu_rd),
    .cpu_stall (cpu_stall),
    .ps2_valid (ps2_valid),
    .ps2_data  (ps2_data),
    .ps2_ready (ps2_ready),
    .vga_req   (vga_req),
    .vga_rd    (vga_rd),
    .vga_valid (vga_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  assign mem_rd = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wd;
    if (mem_we && mem_addr == 6'd62) ps2_wr_cnt <= ps2_wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, vcnt, w0;

    // reset with every requester active
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h10; cpu_wd = 32'h1234_5678;
    ps2_valid = 1'b1; ps2_data = 32'h77; vga_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_mem_we",    mem_we,    1'b0);
      chk("rst_stall",     cpu_stall, 1'b0);
      chk("rst_ps2_ready", ps2_ready, 1'b0);
      chk("rst_vga_valid", vga_valid, 1'b0);
    end
    chk("rst_vga_rd", vga_rd, 32'h0);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ps2_valid = 1'b0; vga_req = 1'b0;
    #1;
    chk("rst_ram_untouched", ram[4], 32'h0);
    chk("ready_low_at_release", ps2_ready, 1'b0);
    @(negedge clk); #1;
    chk("ready_rise", ps2_ready, 1'b1);

    // CPU only
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h10; cpu_wd = 32'hDEAD_BEEF;
    #1;
    chk("cpu_st_stall", cpu_stall, 1'b0);
    chk("cpu_st_we",    mem_we,    1'b1);
    chk("cpu_st_addr",  mem_addr,  6'd4);
    chk("cpu_st_wd",    mem_wd,    32'hDEAD_BEEF);
    @(negedge clk);
    cpu_we = 1'b0; cpu_a = 32'h8000_0013;
    #1;
    chk("cpu_ld_stall", cpu_stall, 1'b0);
    chk("cpu_ld_addr",  mem_addr,  6'd4);
    chk("cpu_ld_rd",    cpu_rd,    32'hDEAD_BEEF);
    @(negedge clk);
    cpu_we = 1'b1; cpu_a = 32'hFC; cpu_wd = 32'hA5;
    #1;
    chk("cpu_st_vga_word_addr", mem_addr, 6'd63);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("cpu_st_vga_word_ram", ram[63], 32'hA5);

    // single PS/2 write under idle CPU
    @(negedge clk);
    ps2_valid = 1'b1; ps2_data = 32'h1C;
    #1;
    chk("ps2_ready_n", ps2_ready, 1'b1);
    @(negedge clk);
    ps2_valid = 1'b0;
    #1;
    chk("ps2_ready_n1", ps2_ready, 1'b0);
    chk("ps2_wr_we",    mem_we,    1'b1);
    chk("ps2_wr_addr",  mem_addr,  6'd62);
    chk("ps2_wr_wd",    mem_wd,    32'h1C);
    @(negedge clk); #1;
    chk("ps2_ready_n2", ps2_ready, 1'b1);
    chk("ps2_ram62",    ram[62],   32'h1C);

    // VGA read of the mailbox word
    @(negedge clk);
    vga_req = 1'b1;
    #1;
    chk("vga_valid_n", vga_valid, 1'b0);
    @(negedge clk);
    vga_req = 1'b0;
    #1;
    chk("vga_grant_addr", mem_addr,  6'd63);
    chk("vga_grant_we",   mem_we,    1'b0);
    chk("vga_valid_n1",   vga_valid, 1'b0);
    @(negedge clk); #1;
    chk("vga_valid_n2", vga_valid, 1'b1);
    chk("vga_rd_n2",    vga_rd,    32'hA5);
    @(negedge clk); #1;
    chk("vga_valid_n3", vga_valid, 1'b0);

    // starvation bound: CPU x4, PS2, CPU x4, VGA
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h10;
    ps2_valid = 1'b1; ps2_data = 32'h55; vga_req = 1'b1;
    #1;
    chk("starve_c0_stall", cpu_stall, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) begin ps2_valid = 1'b0; vga_req = 1'b0; end
      #1;
      chk($sformatf("starve_c%0d_stall", i), cpu_stall, (i == 5 || i == 10) ? 1'b1 : 1'b0);
      if (i == 5) begin
        chk("starve_ps2_addr", mem_addr, 6'd62);
        chk("starve_ps2_we",   mem_we,   1'b1);
      end else if (i == 10) begin
        chk("starve_vga_addr", mem_addr, 6'd63);
      end else begin
        chk($sformatf("starve_c%0d_cpu_addr", i), mem_addr, 6'd4);
      end
    end
    chk("starve_vga_valid", vga_valid, 1'b1);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("starve_ram62", ram[62], 32'h55);

    // reset while a PS/2 word and a VGA request are pending behind the CPU
    @(negedge clk);
    cpu_req = 1'b1; ps2_valid = 1'b1; ps2_data = 32'h99; vga_req = 1'b1;
    #1;
    chk("rstmid_c0_stall", cpu_stall, 1'b0);
    @(negedge clk);
    ps2_valid = 1'b0; vga_req = 1'b0; rst = 1'b1;
    #1;
    chk("rstmid_c1_we", mem_we, 1'b0);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    chk("rstmid_c2_we",    mem_we,    1'b0);
    chk("rstmid_c2_ready", ps2_ready, 1'b0);
    @(negedge clk); #1;
    chk("rstmid_c3_we",    mem_we,    1'b0);
    chk("rstmid_c3_valid", vga_valid, 1'b0);
    chk("rstmid_ram62",    ram[62],   32'h55);

    // two VGA pulses with a one-cycle gap
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vga_req = (i == 0 || i == 2);
      #1;
      if (vga_valid) vcnt++;
    end
    vga_req = 1'b0;
    chk("vga_merge_cnt", vcnt, 2);
    chk("vga_merge_rd",  vga_rd, 32'hA5);

    // five back-to-back PS/2 offers
    w0 = ps2_wr_cnt;
    k = 0; cyc = 0;
    @(negedge clk);
    ps2_valid = 1'b1; ps2_data = 32'h100;
    while (k < 5 && cyc < 30) begin
      #1;
      if (ps2_ready) k++;
      @(negedge clk);
      cyc++;
      if (k < 5) ps2_data = 32'h100 + k;
      else       ps2_valid = 1'b0;
    end
    ps2_valid = 1'b0;
    chk("ps2_burst_accepts", k,   5);
    chk("ps2_burst_cycles",  cyc, 9);
    @(negedge clk); #1;
    chk("ps2_burst_writes", ps2_wr_cnt - w0, 5);
    chk("ps2_burst_ram62",  ram[62],         32'h104);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
